// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding and default bus widths for the master bridge and slave
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: ACCESS-phase wait counter with expiry compare (used only under APB_TIMEOUT_EN)
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clear the count (asserted while the bridge is in SETUP)
//   inc        : count one ACCESS cycle with PREADY low
//   expired    : this ACCESS cycle is the last one allowed
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] cnt;

    assign expired = inc && (cnt == 8'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a valid/ready command interface into APB3 SETUP/ACCESS transfers
// Macro APB_TIMEOUT_EN: when defined, an ACCESS phase longer than TIMEOUT_CYCLES aborts with rsp_err.
// Ports:
//   PCLK, PRESETn                     : clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata  : local command handshake (one outstanding transfer)
//   rsp_valid/rdata/err               : one-cycle completion pulse, read data, abort flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  : APB request outputs (all registered)
//   PREADY/PRDATA                     : APB slave response
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_t state;
    logic       abort;

    assign cmd_ready = (state == IDLE) && PRESETn;

`ifdef APB_TIMEOUT_EN
    apb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clr     (state == SETUP),
        .inc     ((state == ACCESS) && !PREADY),
        .expired (abort)
    );
`else
    // constant 0 for every legal TIMEOUT_CYCLES: ACCESS waits forever
    assign abort = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    PSEL    <= cmd_valid;
                    PENABLE <= 1'b0;
                    if (cmd_valid) begin
                        state  <= SETUP;
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    // PREADY takes priority over a simultaneous timeout
                    if (PREADY || abort) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !PREADY;
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule
